// File: rtl/dec3to8_strobe_seq.sv
// Buffered 3-to-8 decoder: queues 3-bit codes from a valid/ready stream and
// replays each as a registered one-hot strobe of PULSE_LEN cycles followed by
// GAP_LEN idle cycles.
module dec3to8_strobe_seq #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_code,
    output logic [7:0]               d,
    output logic                     d_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;
    localparam logic [AW:0]   FULL_LVL   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    state_t        state;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    // level is registered, so a code pushed this cycle cannot be popped until the next
    assign pop      = (state == IDLE) && en && !empty;
    assign busy     = (state != IDLE) || !empty;

    // FIFO storage: write the incoming code at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_code;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves level unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Strobe sequencer: pop in IDLE, hold one-hot for PULSE_LEN cycles, then gap
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            d       <= '0;
            d_valid <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        d       <= 8'b1 << mem[rptr];
                        d_valid <= 1'b1;
                        cnt     <= PULSE_LOAD;
                        state   <= PULSE;
                    end else begin
                        d       <= '0;
                        d_valid <= 1'b0;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        d       <= '0;
                        d_valid <= 1'b0;
                        if (GAP_LEN > 0) begin
                            cnt   <= GAP_LOAD;
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    d       <= '0;
                    d_valid <= 1'b0;
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    d       <= '0;
                    d_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec3to8_strobe_seq.sv
// Directed bench for dec3to8_strobe_seq: one instance with default timing and
// one with PULSE_LEN=1, GAP_LEN=0, DEPTH=8 for the full code sweep.
module tb_dec3to8_strobe_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = '0;
    logic       in_ready;
    logic [7:0] d;
    logic       d_valid;
    logic       busy;
    logic [2:0] level;

    logic       en_b = 1'b0;
    logic       in_valid_b = 1'b0;
    logic [2:0] in_code_b = '0;
    logic       in_ready_b;
    logic [7:0] d_b;
    logic       d_valid_b;
    logic       busy_b;
    logic [3:0] level_b;

    int checks = 0;
    int errors = 0;
    logic mon_on = 1'b0;

    always #5 clk = ~clk;

    dec3to8_strobe_seq #(
        .DEPTH(4),
        .PULSE_LEN(4),
        .GAP_LEN(1)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .en(en),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_code(in_code),
        .d(d),
        .d_valid(d_valid),
        .busy(busy),
        .level(level)
    );

    dec3to8_strobe_seq #(
        .DEPTH(8),
        .PULSE_LEN(1),
        .GAP_LEN(0)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .en(en_b),
        .in_valid(in_valid_b),
        .in_ready(in_ready_b),
        .in_code(in_code_b),
        .d(d_b),
        .d_valid(d_valid_b),
        .busy(busy_b),
        .level(level_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pop edge, 4 cycles of one-hot, then 2 zero cycles (GAP + IDLE)
    task automatic expect_pulse(input logic [2:0] code);
        logic [7:0] e;
        for (int c = 0; c < 6; c++) begin
            tick();
            e = (c < 4) ? (8'h01 << code) : 8'h00;
            check("pulse_d", d, e);
            check("pulse_dv", d_valid, (e != 8'h00));
        end
    endtask

    // one-hot and d_valid consistency, every cycle, both instances
    always @(negedge clk) begin
        if (mon_on) begin
            check("onehot_a", ($countones(d) <= 1), 1);
            check("dvalid_a", d_valid, (d != 8'h00));
            check("onehot_b", ($countones(d_b) <= 1), 1);
            check("dvalid_b", d_valid_b, (d_b != 8'h00));
        end
    end

    initial begin
        // reset state
        tick();
        tick();
        check("rst_ready", in_ready, 0);
        check("rst_d", d, 8'h00);
        check("rst_dv", d_valid, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_level_b", level_b, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);
        mon_on = 1'b1;

        // 1: single code 5
        en = 1'b1;
        in_valid = 1'b1;
        in_code = 3'd5;
        tick();
        in_valid = 1'b0;
        check("t1_level", level, 1);
        check("t1_d_zero", d, 8'h00);
        check("t1_busy", busy, 1);
        expect_pulse(3'd5);
        check("t1_busy_end", busy, 0);
        check("t1_level_end", level, 0);

        // 2: fill with 0..3 while en=0, then drain
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_code = 3'(k);
            tick();
        end
        in_valid = 1'b0;
        check("t2_level_full", level, 4);
        check("t2_ready_full", in_ready, 0);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_pulse(3'(k));
        end
        check("t2_busy_end", busy, 0);

        // 3: en=0 holds the queue
        en = 1'b0;
        in_valid = 1'b1;
        in_code = 3'd6;
        tick();
        in_code = 3'd2;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t3_hold_level", level, 2);
            check("t3_hold_d", d, 8'h00);
        end
        en = 1'b1;
        expect_pulse(3'd6);
        expect_pulse(3'd2);
        check("t3_busy_end", busy, 0);

        // 4: code 7 held while full
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_code = 3'(k);
            tick();
        end
        in_code = 3'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_full_level", level, 4);
            check("t4_full_ready", in_ready, 0);
        end
        en = 1'b1;
        tick();
        check("t4_pop_level", level, 3);
        check("t4_pop_ready", in_ready, 1);
        check("t4_pop_d", d, 8'h01);
        tick();
        in_valid = 1'b0;
        check("t4_accept_level", level, 4);
        check("t4_accept_ready", in_ready, 0);
        check("t4_d1", d, 8'h01);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t4_d_tail", d, (c < 2) ? 8'h01 : 8'h00);
        end
        expect_pulse(3'd1);
        expect_pulse(3'd2);
        expect_pulse(3'd3);
        expect_pulse(3'd7);
        check("t4_busy_end", busy, 0);

        // 5: reset in the second cycle of a pulse with 3 codes queued
        en = 1'b0;
        for (int k = 4; k < 8; k++) begin
            in_valid = 1'b1;
            in_code = 3'(k);
            tick();
        end
        in_valid = 1'b0;
        en = 1'b1;
        tick();
        check("t5_first_d", d, 8'h10);
        check("t5_level3", level, 3);
        tick();
        check("t5_second_d", d, 8'h10);
        rst = 1'b1;
        #1;
        check("t5_ready_in_rst", in_ready, 0);
        tick();
        rst = 1'b0;
        check("t5_rst_d", d, 8'h00);
        check("t5_rst_dv", d_valid, 0);
        check("t5_rst_level", level, 0);
        check("t5_rst_busy", busy, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t5_quiet_d", d, 8'h00);
            check("t5_quiet_level", level, 0);
        end

        // 6: sweep 0..7 on the short-pulse instance
        en_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid_b = 1'b1;
            in_code_b = 3'(k);
            tick();
        end
        in_valid_b = 1'b0;
        check("t6_level_full", level_b, 8);
        check("t6_ready_full", in_ready_b, 0);
        en_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t6_d_on", d_b, 8'h01 << k);
            tick();
            check("t6_d_off", d_b, 8'h00);
        end
        check("t6_busy_end", busy_b, 0);
        check("t6_level_end", level_b, 0);

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
